// File: rtl/lbus_access_seq.sv
// Local-bus access sequencer: turns one master request into a held slave access and returns Ack or Err.
// Latency: strobe 1 edge after request; Ack no earlier than MIN_HOLD edges; Err after TIMEOUT edges.
// Backpressure: one access at a time; a held Stb_i after completion is not re-accepted until Stb_i or Cyc_i drops.
//
// Ports:
//   CLK_32, RESET            clock, asynchronous active-high reset
//   Cyc_i, Stb_i, We_i       master cycle / strobe / write enable
//   Adr_i, Dat_i             master address / write data (sampled only when the access is accepted)
//   Dat_o, Ack_o, Err_o      read data, completion pulse, timeout pulse back to the master
//   Adr_slave_i_lbus_reg     held address towards the slave
//   We_slave_i_lbus_reg      held direction towards the slave
//   Dat_slave_io_lbus        held write data towards the slave
//   ack_access_str           one-cycle access strobe
//   ack_access_reg_3         access window level (high for the whole access)
//   Dat_slave_o_lbus         slave read data
//   ack_set_reg              slave acknowledge
//   busy_o                   high whenever the sequencer is not idle
`timescale 1ns/1ps

module lbus_access_seq #(
    parameter int WB_DATA_WIDTH = 16,
    parameter int WB_ADDR_WIDTH = 16,
    parameter int MIN_HOLD      = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic                     CLK_32,
    input  logic                     RESET,
    input  logic                     Cyc_i,
    input  logic                     Stb_i,
    input  logic                     We_i,
    input  logic [WB_ADDR_WIDTH-1:0] Adr_i,
    input  logic [WB_DATA_WIDTH-1:0] Dat_i,
    output logic [WB_DATA_WIDTH-1:0] Dat_o,
    output logic                     Ack_o,
    output logic                     Err_o,
    output logic [WB_ADDR_WIDTH-1:0] Adr_slave_i_lbus_reg,
    output logic                     We_slave_i_lbus_reg,
    output logic [WB_DATA_WIDTH-1:0] Dat_slave_io_lbus,
    output logic                     ack_access_str,
    output logic                     ack_access_reg_3,
    input  logic [WB_DATA_WIDTH-1:0] Dat_slave_o_lbus,
    input  logic                     ack_set_reg,
    output logic                     busy_o
);

    // MIN_HOLD below 2 would let the window close before the half-rate
    // MKO strobes fire; TIMEOUT must fit the 8-bit hold counter.
    if (MIN_HOLD < 2 || TIMEOUT <= MIN_HOLD || TIMEOUT > 255) begin : g_param_check
        $error("lbus_access_seq: MIN_HOLD/TIMEOUT out of range");
    end

    localparam logic [7:0] L_MIN_HOLD = 8'(MIN_HOLD);
    localparam logic [7:0] L_TIMEOUT  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STROBE  = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                     r_state;
    logic [7:0]                 r_hold_cnt;
    logic                       r_ack_seen;
    logic                       r_cool;
    logic [WB_DATA_WIDTH-1:0]   r_dat_o;
    logic                       r_ack;
    logic                       r_err;
    logic [WB_ADDR_WIDTH-1:0]   r_adr;
    logic                       r_we;
    logic [WB_DATA_WIDTH-1:0]   r_wdat;
    logic                       r_str;
    logic                       r_reg3;
    logic                       r_busy;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                     w_state;
    logic [7:0]                 w_hold_cnt;
    logic                       w_ack_seen;
    logic                       w_cool;
    logic [WB_DATA_WIDTH-1:0]   w_dat_o;
    logic                       w_ack;
    logic                       w_err;
    logic [WB_ADDR_WIDTH-1:0]   w_adr;
    logic                       w_we;
    logic [WB_DATA_WIDTH-1:0]   w_wdat;
    logic                       w_str;
    logic                       w_reg3;
    logic                       w_busy;

    logic [7:0]                 w_hold_inc;
    logic                       w_ack_any;

    // Saturating increment: the counter parks at its maximum instead of
    // wrapping back into the "too early to acknowledge" range.
    assign w_hold_inc = (r_hold_cnt == 8'hFF) ? r_hold_cnt : (r_hold_cnt + 8'd1);

    // An acknowledge that arrived before the hold window expired is kept
    // in r_ack_seen so a pulsed ack_set_reg is not lost.
    assign w_ack_any = ack_set_reg | r_ack_seen;

    always_ff @(posedge CLK_32 or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 8'd0;
            r_ack_seen <= 1'b0;
            r_cool     <= 1'b0;
            r_dat_o    <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_adr      <= '0;
            r_we       <= 1'b0;
            r_wdat     <= '0;
            r_str      <= 1'b0;
            r_reg3     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_hold_cnt <= w_hold_cnt;
            r_ack_seen <= w_ack_seen;
            r_cool     <= w_cool;
            r_dat_o    <= w_dat_o;
            r_ack      <= w_ack;
            r_err      <= w_err;
            r_adr      <= w_adr;
            r_we       <= w_we;
            r_wdat     <= w_wdat;
            r_str      <= w_str;
            r_reg3     <= w_reg3;
            r_busy     <= w_busy;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_hold_cnt = r_hold_cnt;
        w_ack_seen = r_ack_seen;
        w_cool     = 1'b0;
        w_dat_o    = r_dat_o;
        w_ack      = 1'b0;
        w_err      = 1'b0;
        w_str      = 1'b0;
        w_reg3     = r_reg3;
        w_adr      = r_adr;
        w_we       = r_we;
        w_wdat     = r_wdat;

        case (r_state)
            S_IDLE: begin
                // r_cool blocks acceptance for one edge after an abort so
                // ack_access_reg_3 is always low for at least two edges and
                // the slave has time to drop a stale ack_set_reg.
                if (!r_cool && Cyc_i && Stb_i) begin
                    w_adr      = Adr_i;
                    w_we       = We_i;
                    w_wdat     = Dat_i;
                    w_str      = 1'b1;
                    w_reg3     = 1'b1;
                    w_hold_cnt = 8'd1;
                    w_ack_seen = 1'b0;
                    w_state    = S_STROBE;
                end
            end

            S_STROBE: begin
                // Fixed single cycle: the slave registers its response on
                // this edge, so neither Cyc_i nor ack_set_reg is looked at.
                w_hold_cnt = w_hold_inc;
                w_state    = S_WAIT;
            end

            S_WAIT: begin
                if (!Cyc_i) begin
                    w_reg3  = 1'b0;
                    w_cool  = 1'b1;
                    w_state = S_IDLE;
                end else if (w_ack_any && (r_hold_cnt >= L_MIN_HOLD)) begin
                    w_reg3  = 1'b0;
                    w_ack   = 1'b1;
                    if (!r_we) begin
                        w_dat_o = Dat_slave_o_lbus;
                    end
                    w_state = S_RELEASE;
                end else if (r_hold_cnt == L_TIMEOUT) begin
                    w_reg3  = 1'b0;
                    w_err   = 1'b1;
                    w_dat_o = '1;
                    w_state = S_RELEASE;
                end else begin
                    w_hold_cnt = w_hold_inc;
                    w_ack_seen = w_ack_any;
                end
            end

            S_RELEASE: begin
                // Wait for the master to end the transfer so a held strobe
                // is not taken as a second request.
                if (!Stb_i || !Cyc_i) begin
                    w_state = S_IDLE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign Dat_o                = r_dat_o;
    assign Ack_o                = r_ack;
    assign Err_o                = r_err;
    assign Adr_slave_i_lbus_reg = r_adr;
    assign We_slave_i_lbus_reg  = r_we;
    assign Dat_slave_io_lbus    = r_wdat;
    assign ack_access_str       = r_str;
    assign ack_access_reg_3     = r_reg3;
    assign busy_o               = r_busy;

endmodule

// File: tb/tb_lbus_access_seq.sv
// Bench for lbus_access_seq: directed scenarios plus randomized accesses against an access-age model.
// Latency: outputs compared every cycle on the falling edge, one half cycle after the DUT updates.
// Backpressure: a reactive slave model answers ack_set_reg with programmable delay, pulse or level.
`timescale 1ns/1ps

module tb_lbus_access_seq;

    localparam int DW       = 16;
    localparam int AW       = 16;
    localparam int MIN_HOLD = 4;
    localparam int TIMEOUT  = 64;

    logic          CLK_32 = 1'b0;
    logic          RESET  = 1'b1;
    logic          Cyc_i  = 1'b0;
    logic          Stb_i  = 1'b0;
    logic          We_i   = 1'b0;
    logic [AW-1:0] Adr_i  = '0;
    logic [DW-1:0] Dat_i  = '0;
    logic [DW-1:0] Dat_o;
    logic          Ack_o;
    logic          Err_o;
    logic [AW-1:0] Adr_slave_i_lbus_reg;
    logic          We_slave_i_lbus_reg;
    logic [DW-1:0] Dat_slave_io_lbus;
    logic          ack_access_str;
    logic          ack_access_reg_3;
    logic [DW-1:0] Dat_slave_o_lbus;
    logic          ack_set_reg;
    logic          busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    lbus_access_seq #(
        .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .MIN_HOLD(MIN_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_32(CLK_32), .RESET(RESET), .Cyc_i(Cyc_i), .Stb_i(Stb_i), .We_i(We_i),
        .Adr_i(Adr_i), .Dat_i(Dat_i), .Dat_o(Dat_o), .Ack_o(Ack_o), .Err_o(Err_o),
        .Adr_slave_i_lbus_reg(Adr_slave_i_lbus_reg), .We_slave_i_lbus_reg(We_slave_i_lbus_reg),
        .Dat_slave_io_lbus(Dat_slave_io_lbus), .ack_access_str(ack_access_str),
        .ack_access_reg_3(ack_access_reg_3), .Dat_slave_o_lbus(Dat_slave_o_lbus),
        .ack_set_reg(ack_set_reg), .busy_o(busy_o)
    );

    initial forever #5 CLK_32 = ~CLK_32;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Slave: registers its response on the edge that sees the strobe,
    // raising ack_set_reg s_delay edges after the access started
    // (0 = never). Level mode holds the ack until one edge after the
    // window closes; pulse mode drops it after one cycle.
    // ------------------------------------------------------------------
    int            s_delay = 1;
    bit            s_pulse = 1'b0;
    logic [DW-1:0] s_rdat  = '0;
    bit            s_armed;
    int            s_cnt;

    always @(posedge CLK_32 or posedge RESET) begin
        if (RESET) begin
            ack_set_reg      <= 1'b0;
            Dat_slave_o_lbus <= '0;
            s_armed          <= 1'b0;
            s_cnt            <= 0;
        end else if (ack_access_str) begin
            Dat_slave_o_lbus <= s_rdat;
            s_armed          <= 1'b0;
            if (s_delay == 1) ack_set_reg <= 1'b1;
            else if (s_delay > 1) begin
                s_armed <= 1'b1;
                s_cnt   <= s_delay - 1;
            end
        end else begin
            if (s_armed) begin
                if (!ack_access_reg_3) s_armed <= 1'b0;
                else if (s_cnt == 1) begin
                    ack_set_reg <= 1'b1;
                    s_armed     <= 1'b0;
                end else s_cnt <= s_cnt - 1;
            end
            if (ack_set_reg && (s_pulse || !ack_access_reg_3)) ack_set_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: an access is described by its age in edges since
    // it was accepted. Age 1 is the fixed strobe cycle; from age 2 on the
    // access ends on abort, on an acknowledge once the age reaches
    // MIN_HOLD, or on reaching TIMEOUT. After Ack/Err the master must
    // drop its strobe; after an abort one idle edge passes before the
    // next request can be taken.
    // ------------------------------------------------------------------
    bit            m_open, m_rel, m_cool, m_seen;
    int            m_age;
    logic [DW-1:0] e_dat_o, e_wdat;
    logic [AW-1:0] e_adr;
    logic          e_we, e_ack, e_err, e_str, e_reg3, e_busy;

    always @(posedge CLK_32 or posedge RESET) begin
        if (RESET) begin
            m_open = 0; m_rel = 0; m_cool = 0; m_seen = 0; m_age = 0;
            e_dat_o = '0; e_wdat = '0; e_adr = '0; e_we = 0;
            e_ack = 0; e_err = 0; e_str = 0; e_reg3 = 0; e_busy = 0;
        end else begin
            e_ack = 0; e_err = 0; e_str = 0;
            if (m_open) begin
                m_age = m_age + 1;
                if (m_age >= 2) begin
                    m_seen = m_seen | ack_set_reg;
                    if (!Cyc_i) begin
                        m_open = 0; e_reg3 = 0; m_cool = 1;
                    end else if (m_seen && m_age >= MIN_HOLD) begin
                        m_open = 0; m_rel = 1; e_reg3 = 0; e_ack = 1;
                        if (!e_we) e_dat_o = Dat_slave_o_lbus;
                    end else if (m_age == TIMEOUT) begin
                        m_open = 0; m_rel = 1; e_reg3 = 0; e_err = 1;
                        e_dat_o = {DW{1'b1}};
                    end
                end
            end else if (m_rel) begin
                if (!Stb_i || !Cyc_i) m_rel = 0;
            end else if (m_cool) begin
                m_cool = 0;
            end else if (Cyc_i && Stb_i) begin
                m_open = 1; m_age = 0; m_seen = 0;
                e_adr = Adr_i; e_we = We_i; e_wdat = Dat_i;
                e_str = 1; e_reg3 = 1;
            end
            e_busy = m_open || m_rel;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK_32) begin
        if (!RESET) begin
            check("Ack_o", Ack_o, e_ack);
            check("Err_o", Err_o, e_err);
            check("Dat_o", Dat_o, e_dat_o);
            check("busy_o", busy_o, e_busy);
            check("ack_access_str", ack_access_str, e_str);
            check("ack_access_reg_3", ack_access_reg_3, e_reg3);
            check("Adr_slave", Adr_slave_i_lbus_reg, e_adr);
            check("We_slave", We_slave_i_lbus_reg, e_we);
            check("Dat_slave_io", Dat_slave_io_lbus, e_wdat);
            check("ack_err_exclusive", Ack_o & Err_o, 0);
        end
    end

    // Event monitor for the hand-computed directed expectations.
    int            cyc_n = 0;
    int            n_str, n_r3, n_r3_ok, n_ack, n_err, t_str, t_ack, t_err;
    logic [DW-1:0] mon_wdat;

    always @(negedge CLK_32) begin
        cyc_n++;
        if (ack_access_str) begin n_str++; t_str = cyc_n; end
        if (ack_access_reg_3) begin
            n_r3++;
            if (Dat_slave_io_lbus == mon_wdat) n_r3_ok++;
        end
        if (Ack_o) begin n_ack++; t_ack = cyc_n; end
        if (Err_o) begin n_err++; t_err = cyc_n; end
    end

    task automatic clr_mon();
        n_str = 0; n_r3 = 0; n_r3_ok = 0; n_ack = 0; n_err = 0;
        t_str = 0; t_ack = 0; t_err = 0;
    endtask

    // One master transfer. Called and returns on a falling edge.
    // res: 1 = Ack, 2 = Err, 3 = aborted, 0 = nothing seen.
    task automatic run_access(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              input int abort_at, input int hold_rel, input bit scramble,
                              input bit keep_cyc, output int res);
        bit got_str;
        int j;
        res = 0;
        got_str = 0;
        Cyc_i = 1; Stb_i = 1; We_i = we; Adr_i = adr; Dat_i = dat;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK_32);
            if (ack_access_str) begin got_str = 1; break; end
        end
        check("accept", got_str, 1);
        if (got_str) begin
            j = 0;
            while (res == 0 && j < TIMEOUT + 8) begin
                if (Ack_o) res = 1;
                else if (Err_o) res = 2;
                else begin
                    if (abort_at > 0 && j == abort_at - 1) begin
                        Cyc_i = 0; Stb_i = 0; res = 3;
                    end else if (scramble) begin
                        We_i = 1'($urandom); Adr_i = AW'($urandom); Dat_i = DW'($urandom);
                    end
                    @(negedge CLK_32);
                    j++;
                end
            end
            check("complete", (res != 0), 1);
            if (res == 1 || res == 2) begin
                repeat (hold_rel) @(negedge CLK_32);
                Stb_i = 0;
                if (!keep_cyc) Cyc_i = 0;
            end
        end
        Stb_i = 0;
        if (!(keep_cyc && (res == 1 || res == 2))) Cyc_i = 0;
        for (int i = 0; i < 8 && busy_o; i++) @(negedge CLK_32);
        check("idle_again", busy_o, 0);
    endtask

    int res;
    int abort_at;

    initial begin
        clr_mon();
        mon_wdat = '0;
        repeat (3) @(negedge CLK_32);
        RESET = 0;
        @(negedge CLK_32);

        // Reset state
        check("rst Dat_o", Dat_o, 0);
        check("rst Ack_o", Ack_o, 0);
        check("rst Err_o", Err_o, 0);
        check("rst busy_o", busy_o, 0);
        check("rst str", ack_access_str, 0);
        check("rst reg3", ack_access_reg_3, 0);
        check("rst Adr_slave", Adr_slave_i_lbus_reg, 0);
        check("rst Dat_slave_io", Dat_slave_io_lbus, 0);

        // Write, slave acks at N+1
        s_delay = 1; s_pulse = 0; s_rdat = 16'h5A5A; mon_wdat = 16'h8015;
        clr_mon();
        run_access(1'b1, 16'hA002, 16'h8015, 0, 0, 1'b1, 1'b0, res);
        check("wr res", res, 1);
        check("wr str cycles", n_str, 1);
        check("wr reg3 cycles", n_r3, 4);
        check("wr held data cycles", n_r3_ok, 4);
        check("wr ack pulses", n_ack, 1);
        check("wr ack latency", t_ack - t_str, 4);
        check("wr err pulses", n_err, 0);
        check("wr Dat_o unchanged", Dat_o, 16'h0000);

        // Read returning 8013
        s_delay = 1; s_rdat = 16'h8013;
        clr_mon();
        run_access(1'b0, 16'hA004, 16'h0000, 0, 0, 1'b1, 1'b0, res);
        check("rd res", res, 1);
        check("rd Dat_o", Dat_o, 16'h8013);
        check("rd ack pulses", n_ack, 1);
        check("rd ack latency", t_ack - t_str, 4);

        // Timeout: slave never answers
        s_delay = 0;
        clr_mon();
        run_access(1'b0, 16'hA006, 16'h0000, 0, 0, 1'b0, 1'b0, res);
        check("to res", res, 2);
        check("to err latency", t_err - t_str, 64);
        check("to err pulses", n_err, 1);
        check("to ack pulses", n_ack, 0);
        check("to Dat_o", Dat_o, 16'hFFFF);
        check("to reg3 low", ack_access_reg_3, 0);
        check("to reg3 cycles", n_r3, 64);

        // Abort: Cyc_i dropped so the edge N+2 sees it low
        s_delay = 0;
        clr_mon();
        run_access(1'b1, 16'h1111, 16'h2222, 2, 0, 1'b0, 1'b0, res);
        check("ab res", res, 3);
        check("ab reg3 cycles", n_r3, 2);
        check("ab ack pulses", n_ack, 0);
        check("ab err pulses", n_err, 0);
        check("ab busy", busy_o, 0);
        check("ab Dat_o kept", Dat_o, 16'hFFFF);
        s_delay = 2; s_rdat = 16'h0F0F;
        clr_mon();
        run_access(1'b0, 16'h3333, 16'h0000, 0, 0, 1'b0, 1'b0, res);
        check("after ab res", res, 1);
        check("after ab Dat_o", Dat_o, 16'h0F0F);

        // Stb_i held 10 cycles after Ack
        s_delay = 1; s_pulse = 1;
        clr_mon();
        run_access(1'b1, 16'h4444, 16'h5555, 0, 10, 1'b0, 1'b1, res);
        check("hold res", res, 1);
        check("hold single access", n_str, 1);
        run_access(1'b1, 16'h4446, 16'h5557, 0, 0, 1'b0, 1'b0, res);
        check("hold second access", n_str, 2);
        check("hold acks", n_ack, 2);

        // Asynchronous reset in the middle of WAIT
        s_delay = 0; s_pulse = 0;
        Cyc_i = 1; Stb_i = 1; We_i = 1; Adr_i = 16'h0BAD; Dat_i = 16'h1234;
        res = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK_32);
            if (ack_access_str) begin res = 1; break; end
        end
        check("rw accept", res, 1);
        @(negedge CLK_32);
        @(posedge CLK_32);
        #2 RESET = 1;
        #1;
        check("arst Dat_o", Dat_o, 0);
        check("arst Ack_o", Ack_o, 0);
        check("arst Err_o", Err_o, 0);
        check("arst busy_o", busy_o, 0);
        check("arst str", ack_access_str, 0);
        check("arst reg3", ack_access_reg_3, 0);
        check("arst Adr_slave", Adr_slave_i_lbus_reg, 0);
        check("arst We_slave", We_slave_i_lbus_reg, 0);
        check("arst Dat_slave_io", Dat_slave_io_lbus, 0);
        Cyc_i = 0; Stb_i = 0;
        #1 RESET = 0;
        @(negedge CLK_32);
        check("arst idle", busy_o, 0);

        // Randomized accesses
        for (int t = 0; t < 160; t++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10)      s_delay = 0;
            else if (r < 15) s_delay = $urandom_range(60, 80);
            else             s_delay = $urandom_range(1, 12);
            s_pulse = 1'($urandom_range(0, 1));
            s_rdat  = DW'($urandom);
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : 0;
            run_access(1'($urandom), AW'($urandom), DW'($urandom), abort_at,
                       $urandom_range(0, 4), 1'b1, 1'($urandom_range(0, 1)), res);
            repeat ($urandom_range(0, 3)) @(negedge CLK_32);
        end

        repeat (4) @(negedge CLK_32);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
